seq_detect_prog: RTL and testbench

Programmable serial sequence detector: the runtime-configurable successor to the team's fixed "11010" detector FSM. It matches a pattern of 1 to MAX_LEN bits against a qualified serial bit stream, with selectable overlapping or non-overlapping detection. It produces a registered one-cycle match pulse and a saturating match counter. It sits on the serial receive path after the bit slicer and feeds framing and statistics logic.

---
 rtl/seq_detect_prog_if.sv | 31 +++
 rtl/seq_detect_prog.sv | 116 +++++++++++
 tb/tb_seq_detect_prog.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_prog_if.sv
// Handshake/config bundle for the programmable sequence detector.
// master drives bits and config; slave returns match, count, err, state.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               in;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic [1:0]         state;

  modport master (
    output in_valid, in, cfg_we, cfg_pattern,
    output cfg_len, cfg_overlap, clr_count,
    input  match, match_count, cfg_err, state
  );

  modport slave (
    input  in_valid, in, cfg_we, cfg_pattern,
    input  cfg_len, cfg_overlap, clr_count,
    output match, match_count, cfg_err, state
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector (1..MAX_LEN bit pattern).
// Ports: clk, rst (async high), bus (slave: bits/config in, match out).
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_1010,
  parameter int                 DEF_LEN     = 5
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_prog_if.slave   bus
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILL     = 2'd1,
    ARMED    = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] L_DEF = LEN_W'(DEF_LEN);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_cfg_ok;
  logic               w_armed_n;

  assign w_hist_n = {r_hist[MAX_LEN-2:0], bus.in};
  assign w_fill_n = (r_fill >= L_MAX) ? L_MAX
                                      : r_fill + 1'b1;

  // Only the low len bits of history/pattern take part.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_armed_n = (w_fill_n >= r_len);
  assign w_hit = (r_state != DISABLED) && w_armed_n &&
                 (((w_hist_n ^ r_pat) & w_mask) == '0);

  assign w_cfg_ok = (bus.cfg_len != '0) &&
                    (bus.cfg_len <= L_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= DEF_PATTERN;
      r_len   <= L_DEF;
      r_ovl   <= 1'b1;
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (bus.cfg_we) begin
        // A config write restarts detection; any bit this cycle is dropped.
        r_pat   <= bus.cfg_pattern;
        r_len   <= bus.cfg_len;
        r_ovl   <= bus.cfg_overlap;
        r_hist  <= '0;
        r_fill  <= '0;
        r_cnt   <= '0;
        r_err   <= ~w_cfg_ok;
        r_state <= w_cfg_ok ? FILL : DISABLED;
      end else begin
        if (bus.clr_count) begin
          r_cnt <= '0;
        end
        if (bus.in_valid && (r_state != DISABLED)) begin
          r_hist <= w_hist_n;
          if (w_hit) begin
            r_match <= 1'b1;
            if (!bus.clr_count && (r_cnt != '1)) begin
              r_cnt <= r_cnt + 1'b1;
            end
            // Non-overlap needs len fresh bits before the next match.
            if (r_ovl) begin
              r_fill  <= w_fill_n;
              r_state <= ARMED;
            end else begin
              r_fill  <= '0;
              r_state <= FILL;
            end
          end else begin
            r_fill  <= w_fill_n;
            r_state <= w_armed_n ? ARMED : FILL;
          end
        end
      end
    end
  end

  assign bus.match       = r_match;
  assign bus.match_count = r_cnt;
  assign bus.cfg_err     = r_err;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog.
// Main instance uses defaults; a second one has CNT_W=2 for saturation.
module tb_seq_detect_prog;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus ();
  seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus2 ();

  seq_detect_prog u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_detect_prog #(.CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in          = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.clr_count   = 1'b0;
    bus2.in_valid    = 1'b0;
    bus2.in          = 1'b0;
    bus2.cfg_we      = 1'b0;
    bus2.cfg_pattern = '0;
    bus2.cfg_len     = '0;
    bus2.cfg_overlap = 1'b0;
    bus2.clr_count   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic b);
    bus.in_valid = 1'b1;
    bus.in       = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                     input logic o);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tot++;
    if (bus.match !== 1'b0)
      $display("FAIL rst_match got %b want 0", bus.match);
    else n_pass++;
    n_tot++;
    if (bus.match_count !== 8'd0)
      $display("FAIL rst_count got %0d want 0", bus.match_count);
    else n_pass++;
    n_tot++;
    if (bus.cfg_err !== 1'b0)
      $display("FAIL rst_err got %b want 0", bus.cfg_err);
    else n_pass++;
    n_tot++;
    if (bus.state !== 2'd1)
      $display("FAIL rst_state got %0d want 1", bus.state);
    else n_pass++;
  endtask

  task automatic test_default();
    logic [9:0] bits = 10'b11010_11010;
    logic [9:0] ex   = 10'b00001_00001;
    logic [5:0] b2   = 6'b111010;
    logic [5:0] e2   = 6'b000001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(bits[9-i]);
      n_tot++;
      if (bus.match !== ex[9-i])
        $display("FAIL dflt bit%0d got %b want %b",
                 i + 1, bus.match, ex[9-i]);
      else n_pass++;
    end
    n_tot++;
    if (bus.match_count !== 8'd2)
      $display("FAIL dflt_count got %0d want 2", bus.match_count);
    else n_pass++;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(b2[5-i]);
      n_tot++;
      if (bus.match !== e2[5-i])
        $display("FAIL dflt2 bit%0d got %b want %b",
                 i + 1, bus.match, e2[5-i]);
      else n_pass++;
    end
  endtask

  task automatic test_overlap();
    logic [4:0] s1 = 5'b10101;
    logic [4:0] e1 = 5'b00101;
    logic [4:0] e2 = 5'b00100;
    logic [5:0] s3 = 6'b101101;
    logic [5:0] e3 = 6'b001001;
    cfg(8'b101, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(s1[4-i]);
      n_tot++;
      if (bus.match !== e1[4-i])
        $display("FAIL ovl1 bit%0d got %b want %b",
                 i + 1, bus.match, e1[4-i]);
      else n_pass++;
    end
    n_tot++;
    if (bus.match_count !== 8'd2)
      $display("FAIL ovl1_count got %0d want 2", bus.match_count);
    else n_pass++;
    cfg(8'b101, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(s1[4-i]);
      n_tot++;
      if (bus.match !== e2[4-i])
        $display("FAIL novl1 bit%0d got %b want %b",
                 i + 1, bus.match, e2[4-i]);
      else n_pass++;
    end
    cfg(8'b101, 4'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(s3[5-i]);
      n_tot++;
      if (bus.match !== e3[5-i])
        $display("FAIL novl2 bit%0d got %b want %b",
                 i + 1, bus.match, e3[5-i]);
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    logic [9:0] bits = 10'b11010_11010;
    logic [9:0] ex   = 10'b00001_00001;
    int         ecnt = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(bits[9-i]);
      if (ex[9-i]) ecnt++;
      n_tot++;
      if (bus.match !== ex[9-i])
        $display("FAIL gap bit%0d got %b want %b",
                 i + 1, bus.match, ex[9-i]);
      else n_pass++;
      for (int g = 0; g < 3; g++) begin
        step();
        n_tot++;
        if (bus.match !== 1'b0 ||
            bus.match_count !== 8'(ecnt))
          $display("FAIL gap_idle bit%0d got m=%b c=%0d want m=0 c=%0d",
                   i + 1, bus.match, bus.match_count, ecnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_disabled();
    logic [4:0] s = 5'b11010;
    cfg(8'b0001_1010, 4'd0, 1'b1);
    n_tot++;
    if (bus.cfg_err !== 1'b1 || bus.state !== 2'd0)
      $display("FAIL len0 got err=%b st=%0d want err=1 st=0",
               bus.cfg_err, bus.state);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      send(s[4-i]);
      n_tot++;
      if (bus.match !== 1'b0)
        $display("FAIL len0_match bit%0d got %b want 0",
                 i + 1, bus.match);
      else n_pass++;
    end
    cfg(8'hFF, 4'd9, 1'b1);
    n_tot++;
    if (bus.cfg_err !== 1'b1 || bus.state !== 2'd0)
      $display("FAIL len9 got err=%b st=%0d want err=1 st=0",
               bus.cfg_err, bus.state);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      send(1'b1);
      n_tot++;
      if (bus.match !== 1'b0)
        $display("FAIL len9_match bit%0d got %b want 0",
                 i + 1, bus.match);
      else n_pass++;
    end
    cfg(8'b1111, 4'd4, 1'b1);
    n_tot++;
    if (bus.cfg_err !== 1'b0 || bus.state !== 2'd1)
      $display("FAIL len4 got err=%b st=%0d want err=0 st=1",
               bus.cfg_err, bus.state);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      n_tot++;
      if (bus.match !== (i == 3))
        $display("FAIL len4_match bit%0d got %b want %b",
                 i + 1, bus.match, (i == 3));
      else n_pass++;
    end
    n_tot++;
    if (bus.state !== 2'd2)
      $display("FAIL len4_state got %0d want 2", bus.state);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [1:0] ec;
    bus2.cfg_we      = 1'b1;
    bus2.cfg_pattern = 8'b1;
    bus2.cfg_len     = 4'd1;
    bus2.cfg_overlap = 1'b1;
    step();
    bus2.cfg_we   = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.in       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ec = (i < 3) ? 2'(i + 1) : 2'd3;
      n_tot++;
      if (bus2.match !== 1'b1 || bus2.match_count !== ec)
        $display("FAIL sat bit%0d got m=%b c=%0d want m=1 c=%0d",
                 i + 1, bus2.match, bus2.match_count, ec);
      else n_pass++;
    end
    bus2.clr_count = 1'b1;
    step();
    bus2.clr_count = 1'b0;
    bus2.in_valid  = 1'b0;
    n_tot++;
    if (bus2.match !== 1'b1 || bus2.match_count !== 2'd0)
      $display("FAIL clr_hit got m=%b c=%0d want m=1 c=0",
               bus2.match, bus2.match_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] s = 5'b11010;
    do_reset();
    for (int i = 0; i < 5; i++) send(s[4-i]);
    n_tot++;
    if (bus.match !== 1'b1)
      $display("FAIL pre_rst_match got %b want 1", bus.match);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_tot++;
    if (bus.match !== 1'b0 || bus.match_count !== 8'd0)
      $display("FAIL async_rst got m=%b c=%0d want m=0 c=0",
               bus.match, bus.match_count);
    else n_pass++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(s[4-i]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(1'b0);
    n_tot++;
    if (bus.match !== 1'b0)
      $display("FAIL rst_restart got %b want 0", bus.match);
    else n_pass++;
    for (int i = 0; i < 5; i++) send(s[4-i]);
    n_tot++;
    if (bus.match !== 1'b1 || bus.match_count !== 8'd1)
      $display("FAIL rst_rematch got m=%b c=%0d want m=1 c=1",
               bus.match, bus.match_count);
    else n_pass++;
  endtask

  task automatic test_cfg_concurrent();
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 8'b11;
    bus.cfg_len     = 4'd2;
    bus.cfg_overlap = 1'b1;
    bus.clr_count   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in          = 1'b1;
    step();
    idle();
    n_tot++;
    if (bus.match_count !== 8'd0 || bus.state !== 2'd1)
      $display("FAIL cfg_clr got c=%0d st=%0d want c=0 st=1",
               bus.match_count, bus.state);
    else n_pass++;
    send(1'b1);
    n_tot++;
    if (bus.match !== 1'b0)
      $display("FAIL cfg_drop got %b want 0", bus.match);
    else n_pass++;
    send(1'b1);
    n_tot++;
    if (bus.match !== 1'b1 || bus.match_count !== 8'd1)
      $display("FAIL cfg_b2b1 got m=%b c=%0d want m=1 c=1",
               bus.match, bus.match_count);
    else n_pass++;
    send(1'b1);
    n_tot++;
    if (bus.match !== 1'b1 || bus.match_count !== 8'd2)
      $display("FAIL cfg_b2b2 got m=%b c=%0d want m=1 c=2",
               bus.match, bus.match_count);
    else n_pass++;
    step();
    n_tot++;
    if (bus.match !== 1'b0)
      $display("FAIL pulse_end got %b want 0", bus.match);
    else n_pass++;
  endtask

  initial begin
    idle();
    test_reset();
    test_default();
    test_overlap();
    test_gaps();
    test_disabled();
    test_saturate();
    test_reset_mid();
    test_cfg_concurrent();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
